// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared defaults and configuration check for the clock divider bank
package clock_divider_pkg;

    localparam int          DEF_CNT_W = 32;
    localparam int unsigned DEF_DIV   = 100_000;

    // A request is usable only when it targets an existing channel and
    // describes a period of at least two cycles whose high time leaves
    // at least one low cycle. Operands arrive zero-extended to 64 bits,
    // so CNT_W must not exceed 64.
    function automatic logic cfg_is_valid(input logic        ch_ok,
                                          input logic [63:0] div,
                                          input logic [63:0] high);
        return ch_ok && (div >= 64'd2) && (high != 64'd0) && (high < div);
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one divider channel: counter, active/pending settings, outputs
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_restart,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_high;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             period_start;

    // A new period begins on start-up, on a sync restart, or when the
    // counter reaches the last cycle of the current period.
    always_comb begin
        period_start = !run || sync_restart || (cnt == (div_q - CNT_W'(1)));
    end

    // Counter, settings and registered outputs. A write is only ever
    // presented while pend is clear, so it never collides with the
    // pending-apply path and the pend<=1 below always wins.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            div_q     <= CNT_W'(DEFAULT_DIV);
            high_q    <= CNT_W'(DEFAULT_DIV / 2);
            pend_div  <= '0;
            pend_high <= '0;
            pend      <= 1'b0;
            run       <= 1'b0;
            cnt       <= '0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            if (!en) begin
                run     <= 1'b0;
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (period_start) begin
                run     <= 1'b1;
                cnt     <= '0;
                tick    <= 1'b1;
                clk_out <= 1'b1;
                if (pend) begin
                    div_q  <= pend_div;
                    high_q <= pend_high;
                    pend   <= 1'b0;
                end
            end else begin
                cnt     <= cnt + CNT_W'(1);
                tick    <= 1'b0;
                clk_out <= ((cnt + CNT_W'(1)) < high_q);
            end
            if (wr_en) begin
                pend_div  <= wr_div;
                pend_high <= wr_high;
                pend      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of independent programmable clock dividers
module clock_divider_bank
    import clock_divider_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0]      pend;
    logic [NUM_CH-1:0]      wr_en;
    logic [(1<<CH_W)-1:0]   pend_pad;
    logic                   ch_ok;
    logic                   cfg_accept;
    logic                   cfg_good;

    // Pad the pend vector to the full cfg_ch range so the ready mux
    // never indexes past the last channel.
    always_comb begin
        pend_pad             = '0;
        pend_pad[NUM_CH-1:0] = pend;
    end

    // Handshake decode: out-of-range channels are always ready so the
    // request can complete and be reported as an error.
    always_comb begin
        ch_ok      = (int'(cfg_ch) < NUM_CH);
        cfg_ready  = ch_ok ? !pend_pad[cfg_ch] : 1'b1;
        cfg_accept = cfg_valid && cfg_ready;
        cfg_good   = cfg_accept && cfg_is_valid(ch_ok, 64'(cfg_div), 64'(cfg_high));
    end

    // One-cycle error pulse for an accepted but unusable request.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_accept && !cfg_good;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en[i] = cfg_good && (int'(cfg_ch) == i);

        clock_divider_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in       (clk_in),
            .reset        (reset),
            .en           (ch_en[i]),
            .sync_restart (sync_restart),
            .wr_en        (wr_en[i]),
            .wr_div       (cfg_div),
            .wr_high      (cfg_high),
            .pend         (pend[i]),
            .clk_out      (clk_out[i]),
            .tick         (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - randomized and directed self-checking bench for clock_divider_bank
module tb_clock_divider_bank;

    localparam int NUM_CH      = 5;
    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 10;
    localparam int CH_W        = 3;
    localparam int LOGN        = 512;

    logic              clk_in = 1'b0;
    logic              reset = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [CNT_W-1:0]  cfg_high = '0;
    logic              cfg_err;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              sync_restart = 1'b0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clock_divider_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_high     (cfg_high),
        .cfg_err      (cfg_err),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .clk_out      (clk_out),
        .tick         (tick)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel is described by the edge index at
    // which its current period began; outputs follow from elapsed time.
    int m_div   [NUM_CH];
    int m_high  [NUM_CH];
    int m_pdiv  [NUM_CH];
    int m_phigh [NUM_CH];
    int m_start [NUM_CH];
    bit m_pend  [NUM_CH];
    bit m_run   [NUM_CH];
    logic [NUM_CH-1:0] e_clk = '0;
    logic [NUM_CH-1:0] e_tick = '0;
    logic              e_err = 1'b0;
    int cyc = 0;

    logic [NUM_CH-1:0] log_clk  [LOGN];
    logic [NUM_CH-1:0] log_tick [LOGN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready();
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    task automatic model_step();
        bit acc;
        bit good;
        int c;
        cyc++;
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i]  = DEFAULT_DIV;
                m_high[i] = DEFAULT_DIV / 2;
                m_pend[i] = 1'b0;
                m_run[i]  = 1'b0;
            end
            e_clk  = '0;
            e_tick = '0;
            e_err  = 1'b0;
        end else begin
            c     = int'(cfg_ch);
            acc   = cfg_valid && m_ready();
            good  = acc && (c < NUM_CH) && (cfg_div >= 2) && (cfg_high != 0) && (cfg_high < cfg_div);
            e_err = acc && !good;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_en[i]) begin
                    m_run[i]  = 1'b0;
                    e_clk[i]  = 1'b0;
                    e_tick[i] = 1'b0;
                end else begin
                    if (!m_run[i] || sync_restart || (cyc - m_start[i] == m_div[i])) begin
                        m_start[i] = cyc;
                        m_run[i]   = 1'b1;
                        if (m_pend[i]) begin
                            m_div[i]  = m_pdiv[i];
                            m_high[i] = m_phigh[i];
                            m_pend[i] = 1'b0;
                        end
                    end
                    e_tick[i] = (cyc == m_start[i]);
                    e_clk[i]  = ((cyc - m_start[i]) < m_high[i]);
                end
                if (good && c == i) begin
                    m_pdiv[i]  = int'(cfg_div);
                    m_phigh[i] = int'(cfg_high);
                    m_pend[i]  = 1'b1;
                end
            end
        end
    endtask

    // One clock: inputs are already driven; check the combinational
    // ready, advance the model, then compare registered outputs.
    task automatic cycle();
        #1;
        if (cyc > 0) check("cfg_ready", cfg_ready, m_ready());
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
        check("clk_out", clk_out, e_clk);
        check("tick", tick, e_tick);
        check("cfg_err", cfg_err, e_err);
        if (cyc < LOGN) begin
            log_clk[cyc]  = clk_out;
            log_tick[cyc] = tick;
        end
    endtask

    task automatic write(input int ch, input int div, input int high);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(div);
        cfg_high  = CNT_W'(high);
        cycle();
        cfg_valid = 1'b0;
    endtask

    function automatic int count_bits(input int ch, input int from, input int to, input bit use_tick);
        int n = 0;
        for (int k = from; k <= to; k++) begin
            if (use_tick) n += int'(log_tick[k][ch]);
            else          n += int'(log_clk[k][ch]);
        end
        return n;
    endfunction

    int k0, tw, e1, acc_edge, stalls, guard, ts, r;
    int bad_tab [4][3] = '{'{0, 1, 1}, '{0, 8, 8}, '{0, 8, 0}, '{5, 8, 3}};

    initial begin
        @(negedge clk_in);
        reset = 1'b0;
        cycle();
        cycle();
        check("reset_clk_out", clk_out, 0);
        check("reset_tick", tick, 0);
        check("reset_cfg_err", cfg_err, 0);

        // Default divisor on channel 0.
        reset = 1'b1;
        ch_en = 5'b00001;
        cycle();
        k0 = cyc;
        check("first_tick", tick[0], 1);
        check("first_high", clk_out[0], 1);
        repeat (29) cycle();
        check("default_ticks_30", count_bits(0, k0, k0 + 29, 1), 3);
        check("default_high_30", count_bits(0, k0, k0 + 29, 0), 15);

        // Mid-period reconfiguration.
        repeat (3) cycle();
        write(0, 6, 2);
        tw = cyc;
        repeat (22) cycle();
        check("old_high_phase4", log_clk[tw + 1][0], 1);
        check("old_high_phase5", log_clk[tw + 2][0], 0);
        check("no_early_tick", count_bits(0, tw + 1, tw + 6, 1), 0);
        check("old_period_end_tick", log_tick[tw + 7][0], 1);
        check("new_period_tick", log_tick[tw + 13][0], 1);
        check("new_high_count", count_bits(0, tw + 7, tw + 12, 0), 2);

        // Rejected requests.
        for (int j = 0; j < 4; j++) begin
            write(bad_tab[j][0], bad_tab[j][1], bad_tab[j][2]);
            check("err_pulse", cfg_err, 1);
        end
        cycle();
        check("err_cleared", cfg_err, 0);
        repeat (12) cycle();
        check("div6_kept", count_bits(0, cyc - 11, cyc, 1), 2);

        // Back-to-back requests to channel 1.
        ch_en = 5'b00011;
        cycle();
        e1 = cyc;
        check("ch1_start_tick", log_tick[e1][1], 1);
        write(1, 4, 1);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(6);
        cfg_high  = CNT_W'(3);
        stalls    = 0;
        guard     = 0;
        acc_edge  = -1;
        while (acc_edge < 0 && guard < 50) begin
            #1;
            if (cfg_ready) begin
                cycle();
                acc_edge = cyc;
            end else begin
                stalls++;
                cycle();
            end
            guard++;
        end
        cfg_valid = 1'b0;
        check("stall_cycles", stalls, 9);
        check("accept_edge", acc_edge - e1, 11);
        repeat (16) cycle();
        check("ch1_first_wrap", log_tick[e1 + 10][1], 1);
        check("ch1_div4_wrap", log_tick[e1 + 14][1], 1);
        check("ch1_no_div4_again", log_tick[e1 + 18][1], 0);
        check("ch1_div6_wrap", log_tick[e1 + 20][1], 1);

        // Phase-aligned restart.
        write(0, 4, 2);
        repeat (8) cycle();
        sync_restart = 1'b1;
        cycle();
        ts = cyc;
        sync_restart = 1'b0;
        repeat (12) cycle();
        check("sync_tick", log_tick[ts][1:0], 2'b11);
        check("sync_clk", log_clk[ts][1:0], 2'b11);
        check("sync_ch0_next", log_tick[ts + 4][0], 1);
        check("sync_ch1_next", log_tick[ts + 6][1], 1);
        check("sync_realign", log_tick[ts + 12][1:0], 2'b11);

        // Reset with a pending write.
        write(0, 8, 3);
        reset = 1'b0;
        cycle();
        check("midreset_clk", clk_out, 0);
        check("midreset_tick", tick, 0);
        reset = 1'b1;
        cycle();
        r = cyc;
        repeat (12) cycle();
        check("post_reset_tick", log_tick[r][0], 1);
        check("pending_lost", log_tick[r + 8][0], 0);
        check("post_reset_period", log_tick[r + 10][0], 1);

        // Randomized traffic against the model.
        repeat (3000) begin
            reset        = ($urandom_range(0, 99) != 0);
            cfg_valid    = ($urandom_range(0, 2) == 0);
            cfg_ch       = CH_W'($urandom_range(0, 7));
            cfg_div      = CNT_W'($urandom_range(0, 12));
            cfg_high     = CNT_W'($urandom_range(0, int'(cfg_div) + 1));
            sync_restart = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) ch_en = NUM_CH'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32, counter and divisor width in bits.
REQ-003 Parameter DEFAULT_DIV, default 100_000, post-reset divisor of every channel; SHALL be >= 2.
REQ-004 clk_in  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 cfg_valid  in  1  configuration request.
REQ-007 cfg_ready  out  1  combinational, = !pend[cfg_ch], or 1 when cfg_ch >= NUM_CH.
REQ-008 cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
REQ-009 cfg_div  in  CNT_W  requested period in clk_in cycles.
REQ-010 cfg_high  in  CNT_W  requested high time in clk_in cycles.
REQ-011 cfg_err  out  1  one-cycle pulse: accepted request rejected.
REQ-012 ch_en  in  NUM_CH  per-channel run enable.
REQ-013 sync_restart  in  1  restart all enabled channels in phase.
REQ-014 clk_out  out  NUM_CH  registered divided clocks.
REQ-015 tick  out  NUM_CH  registered one-cycle pulse at each period start.

Function
REQ-016 Per channel: active div/high registers, pending div/high plus pend flag, counter cnt, run flag.
REQ-017 Handshake completes on cfg_valid && cfg_ready in the same cycle; no other cycle changes configuration.
REQ-018 Accepted request SHALL be rejected (cfg_err=1 next cycle, no state change) if cfg_ch >= NUM_CH, cfg_div < 2, cfg_high == 0 or cfg_high >= cfg_div.
REQ-019 Valid accepted request: pending <= cfg_div/cfg_high, pend <= 1; cfg_err stays 0.
REQ-020 ch_en[i]=0: run<=0, cnt<=0, clk_out[i]<=0, tick[i]<=0 at the next edge; pending retained.
REQ-021 Start (ch_en[i]=1, run=0): run<=1, cnt<=0, tick[i]<=1, clk_out[i]<=1; pending applied first if pend=1 (pend<=0).
REQ-022 Running, cnt != div-1: cnt<=cnt+1, tick<=0, clk_out<=(cnt+1 < high).
REQ-023 Running, cnt == div-1 (wrap): cnt<=0, tick<=1, clk_out<=1; pending applied and pend<=0 if pend=1.
REQ-024 Output period exactly div cycles, clk_out high exactly high cycles per period, tick once per period aligned to clk_out rising.
REQ-025 Configuration never alters a period in progress; changes take effect only at start, wrap or sync_restart.
REQ-026 Request accepted in the same cycle as a wrap of its channel: the wrap uses the old pend state; new values apply at the following wrap.
REQ-027 sync_restart=1: every channel with ch_en=1 behaves as REQ-021 regardless of run/cnt; overrides REQ-022/023; disabled channels unaffected.
REQ-028 Second request to a channel with pend=1 is stalled (cfg_ready=0); no overwrite.
REQ-029 cnt arithmetic CNT_W bits, never exceeds div-1; no wrap of the CNT_W counter possible.

Reset
REQ-030 reset=0 at an edge: active div=DEFAULT_DIV, high=DEFAULT_DIV/2, pend=0, run=0, cnt=0, clk_out=0, tick=0, cfg_err=0; overrides all other inputs.
REQ-031 Reset mid-period discards pending configuration; first edge with reset=1 and ch_en=1 performs REQ-021.

Structure
REQ-032 Package clock_divider_pkg SHALL hold CNT_W default, DEFAULT_DIV default and the config-validity check function.
REQ-033 One sub-module clock_divider_channel (counter, active/pending registers, outputs) instantiated NUM_CH times; top holds cfg decode, cfg_ready mux and cfg_err.

Verification
REQ-034 Reset, ch_en=0001, no cfg, DEFAULT_DIV=10 -> clk_out[0] period 10, high 5, tick every 10 cycles, first tick on first enabled edge.
REQ-035 ch 0 running div=10; mid-period write div=6 high=2 -> current period stays 10, next periods 6 with high 2.
REQ-036 Writes div=1, div=8 high=8, high=0, cfg_ch=5 (NUM_CH=4) -> cfg_err pulse each, configuration unchanged.
REQ-037 Two back-to-back writes to ch 1 before its wrap -> cfg_ready=0 on second until wrap, second applied one period later.
REQ-038 ch 0 div=4, ch 1 div=6, sync_restart pulse -> both tick same cycle, clk_out rising edges coincide next cycle.
REQ-039 Reset asserted mid-period with pend=1 -> all outputs 0, post-reset period DEFAULT_DIV, pending lost.
